// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared state encoding and defaults for the pixel conversion sequencer
package pixel_pkg;

  localparam int DEFAULT_BIT_DEPTH = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ERASE   = 3'd1,
    ST_EXPOSE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_READ    = 3'd4
  } seq_state_t;

  function automatic int max_of3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/pixel_conversion_sequencer_phase_timer.sv
// rtl/pixel_conversion_sequencer_phase_timer.sv - loadable saturating down-counter with terminal-count flag
module phase_timer #(
  parameter int WIDTH = 8
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             terminal
);

  logic [WIDTH-1:0] count;

  // Load wins; otherwise count down and park at zero so a finished phase never wraps
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign terminal = (count == '0);

endmodule

// File: rtl/pixel_conversion_sequencer.sv
// rtl/pixel_conversion_sequencer.sv - erase/expose/convert/read frame sequencer (PIXEL_SEQ_CONTINUOUS_EN: free-running frames)
module pixel_conversion_sequencer
  import pixel_pkg::*;
#(
  parameter int BIT_DEPTH     = DEFAULT_BIT_DEPTH,
  parameter int ERASE_CYCLES  = 5,
  parameter int EXPOSE_CYCLES = 255,
  parameter int NUM_ROWS      = 2,
  localparam int ROW_W        = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             START,
  input  logic             ROW_READY,
  output logic             BUSY,
  output logic             ERASE,
  output logic             EXPOSE,
  output logic             COUNTER_RESET,
  output logic             COUNTER_ENABLE,
  output logic             ROW_VALID,
  output logic [ROW_W-1:0] ROW_SELECT,
  output logic             FRAME_DONE
);

  // CONVERT spends one counter-reset cycle plus 2^BIT_DEPTH enable cycles,
  // so loading 2^BIT_DEPTH makes the timer hit zero on the last enable cycle.
  localparam int CONVERT_COUNT = 2 ** BIT_DEPTH;
  localparam int TIMER_MAX     = max_of3(ERASE_CYCLES - 1, EXPOSE_CYCLES - 1, CONVERT_COUNT);
  localparam int TIMER_W       = $clog2(TIMER_MAX + 1);

  localparam logic [TIMER_W-1:0] ERASE_LOAD   = TIMER_W'(ERASE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] EXPOSE_LOAD  = TIMER_W'(EXPOSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] CONVERT_LOAD = TIMER_W'(CONVERT_COUNT);
  localparam logic [ROW_W-1:0]   LAST_ROW     = ROW_W'(NUM_ROWS - 1);

  seq_state_t         state;
  seq_state_t         next_state;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_load_value;
  logic               timer_tc;
  logic               handshake;
  logic               last_row;
  logic               frame_end;

  logic               busy_d;
  logic               erase_d;
  logic               expose_d;
  logic               counter_reset_d;
  logic               counter_enable_d;
  logic               row_valid_d;
  logic [ROW_W-1:0]   row_select_d;

  phase_timer #(
    .WIDTH(TIMER_W)
  ) u_phase_timer (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .load       (timer_load),
    .load_value (timer_load_value),
    .terminal   (timer_tc)
  );

  assign handshake = ROW_VALID & ROW_READY;
  assign last_row  = (ROW_SELECT == LAST_ROW);

  // State register
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; the shared timer is reloaded on every entry into a timed phase
  always_comb begin
    next_state       = state;
    timer_load       = 1'b0;
    timer_load_value = '0;
    frame_end        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) begin
          next_state       = ST_ERASE;
          timer_load       = 1'b1;
          timer_load_value = ERASE_LOAD;
        end
      end
      ST_ERASE: begin
        if (timer_tc) begin
          next_state       = ST_EXPOSE;
          timer_load       = 1'b1;
          timer_load_value = EXPOSE_LOAD;
        end
      end
      ST_EXPOSE: begin
        if (timer_tc) begin
          next_state       = ST_CONVERT;
          timer_load       = 1'b1;
          timer_load_value = CONVERT_LOAD;
        end
      end
      ST_CONVERT: begin
        if (timer_tc) begin
          next_state = ST_READ;
        end
      end
      ST_READ: begin
        if (handshake && last_row) begin
          frame_end = 1'b1;
`ifdef PIXEL_SEQ_CONTINUOUS_EN
          next_state       = ST_ERASE;
          timer_load       = 1'b1;
          timer_load_value = ERASE_LOAD;
`else
          next_state = ST_IDLE;
`endif
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with it
  always_comb begin
    busy_d           = (next_state != ST_IDLE);
    erase_d          = (next_state == ST_ERASE);
    expose_d         = (next_state == ST_EXPOSE);
    counter_reset_d  = (next_state == ST_CONVERT) && (state != ST_CONVERT);
    counter_enable_d = (next_state == ST_CONVERT) && (state == ST_CONVERT);
    row_valid_d      = (next_state == ST_READ);
    row_select_d     = '0;
    if ((next_state == ST_READ) && (state == ST_READ)) begin
      row_select_d = handshake ? (ROW_SELECT + ROW_W'(1)) : ROW_SELECT;
    end
  end

  // Output registers; the counter is held cleared while in reset
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      BUSY           <= 1'b0;
      ERASE          <= 1'b0;
      EXPOSE         <= 1'b0;
      COUNTER_RESET  <= 1'b1;
      COUNTER_ENABLE <= 1'b0;
      ROW_VALID      <= 1'b0;
      ROW_SELECT     <= '0;
      FRAME_DONE     <= 1'b0;
    end else begin
      BUSY           <= busy_d;
      ERASE          <= erase_d;
      EXPOSE         <= expose_d;
      COUNTER_RESET  <= counter_reset_d;
      COUNTER_ENABLE <= counter_enable_d;
      ROW_VALID      <= row_valid_d;
      ROW_SELECT     <= row_select_d;
      FRAME_DONE     <= frame_end;
    end
  end

endmodule

// File: tb/tb_pixel_conversion_sequencer.sv
// tb/tb_pixel_conversion_sequencer.sv - randomized model-based bench for pixel_conversion_sequencer
`timescale 1ns/1ps
module tb_pixel_conversion_sequencer;

  typedef struct {
    int e;
    int x;
    int c;
    int r;
    bit cont;
  } cfg_t;

  typedef struct {
    bit active;
    int t;
    int row;
    bit done;
  } mdl_t;

  typedef struct packed {
    logic       busy;
    logic       erase;
    logic       expose;
    logic       crst;
    logic       cen;
    logic       rvalid;
    logic       fdone;
    logic [7:0] rsel;
  } obs_t;

  localparam int M_BD = 10, M_E = 5, M_X = 255, M_R = 2;
  localparam int E_BD = 2, E_E = 1, E_X = 1, E_R = 1;
`ifdef PIXEL_SEQ_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_start = 1'b0, m_ready = 1'b0, e_start = 1'b0, e_ready = 1'b0;
  logic m_busy, m_erase, m_expose, m_crst, m_cen, m_rv, m_fd;
  logic e_busy, e_erase, e_expose, e_crst, e_cen, e_rv, e_fd;
  logic [0:0] m_sel, e_sel;
  obs_t obs_m, obs_e;

  cfg_t cfg_m, cfg_e;
  mdl_t mm, me;
  mdl_t idle_mdl;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pixel_conversion_sequencer #(
    .BIT_DEPTH(M_BD), .ERASE_CYCLES(M_E), .EXPOSE_CYCLES(M_X), .NUM_ROWS(M_R)
  ) u_main (
    .CLOCK(clk), .RESET(rst), .START(m_start), .ROW_READY(m_ready),
    .BUSY(m_busy), .ERASE(m_erase), .EXPOSE(m_expose), .COUNTER_RESET(m_crst),
    .COUNTER_ENABLE(m_cen), .ROW_VALID(m_rv), .ROW_SELECT(m_sel), .FRAME_DONE(m_fd)
  );

  pixel_conversion_sequencer #(
    .BIT_DEPTH(E_BD), .ERASE_CYCLES(E_E), .EXPOSE_CYCLES(E_X), .NUM_ROWS(E_R)
  ) u_edge (
    .CLOCK(clk), .RESET(rst), .START(e_start), .ROW_READY(e_ready),
    .BUSY(e_busy), .ERASE(e_erase), .EXPOSE(e_expose), .COUNTER_RESET(e_crst),
    .COUNTER_ENABLE(e_cen), .ROW_VALID(e_rv), .ROW_SELECT(e_sel), .FRAME_DONE(e_fd)
  );

  assign obs_m = {m_busy, m_erase, m_expose, m_crst, m_cen, m_rv, m_fd, 8'(m_sel)};
  assign obs_e = {e_busy, e_erase, e_expose, e_crst, e_cen, e_rv, e_fd, 8'(e_sel)};

  // Expected outputs from the position t inside the frame (t=1 is the first ERASE cycle)
  function automatic obs_t expect_of(input cfg_t c, input mdl_t m);
    obs_t o;
    int   l;
    o = '0;
    l = c.e + c.x + 1 + c.c;
    o.fdone = m.done;
    if (m.active) begin
      o.busy = 1'b1;
      if (m.t <= c.e)              o.erase  = 1'b1;
      else if (m.t <= c.e + c.x)   o.expose = 1'b1;
      else if (m.t == c.e + c.x + 1) o.crst = 1'b1;
      else if (m.t <= l)           o.cen    = 1'b1;
      else begin
        o.rvalid = 1'b1;
        o.rsel   = 8'(m.row);
      end
    end
    return o;
  endfunction

  // Advance the frame model by one cycle given this cycle's inputs
  function automatic mdl_t step(input cfg_t c, input mdl_t m, input logic start, input logic ready);
    mdl_t n;
    int   l;
    n = m;
    n.done = 1'b0;
    l = c.e + c.x + 1 + c.c;
    if (!m.active) begin
      if (start) begin
        n.active = 1'b1;
        n.t = 1;
        n.row = 0;
      end
    end else if (m.t <= l) begin
      n.t = m.t + 1;
    end else if (ready) begin
      if (m.row == c.r - 1) begin
        n.done = 1'b1;
        if (c.cont) begin
          n.t = 1;
          n.row = 0;
        end else begin
          n.active = 1'b0;
        end
      end else begin
        n.row = m.row + 1;
      end
    end
    return n;
  endfunction

  task automatic tick();
    mdl_t nm, ne;
    nm = step(cfg_m, mm, m_start, m_ready);
    ne = step(cfg_e, me, e_start, e_ready);
    @(posedge clk);
    #1;
    mm = nm;
    me = ne;
  endtask

  task automatic test_reset();
    obs_t rexp;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rexp = '0;
    rexp.crst = 1'b1;
    tests++;
    if (obs_m !== rexp) begin fails++; $display("FAIL reset_main: got %h expected %h", obs_m, rexp); end
    tests++;
    if (obs_e !== rexp) begin fails++; $display("FAIL reset_edge: got %h expected %h", obs_e, rexp); end
    rst = 1'b0;
    mm = idle_mdl;
    me = idle_mdl;
    repeat (4) begin
      tick();
      tests++;
      if (obs_m !== expect_of(cfg_m, mm)) begin fails++; $display("FAIL reset_idle: got %h expected %h", obs_m, expect_of(cfg_m, mm)); end
    end
  endtask

  task automatic test_basic_frame();
    int done_cyc, n_erase, n_expose, n_crst, n_cen;
    done_cyc = -1; n_erase = 0; n_expose = 0; n_crst = 0; n_cen = 0;
    m_ready = 1'b1;
    m_start = 1'b1;
    tick();
    m_start = 1'b0;
    for (int cyc = 1; cyc < 3000 && done_cyc < 0; cyc++) begin
      tests++;
      if (obs_m !== expect_of(cfg_m, mm)) begin fails++; $display("FAIL basic_frame cyc %0d: got %h expected %h", cyc, obs_m, expect_of(cfg_m, mm)); end
      tests++;
      if ($countones({obs_m.erase, obs_m.expose, obs_m.cen, obs_m.rvalid}) > 1) begin fails++; $display("FAIL basic_exclusive cyc %0d: got %h", cyc, obs_m); end
      n_erase += int'(obs_m.erase);
      n_expose += int'(obs_m.expose);
      n_crst += int'(obs_m.crst);
      n_cen += int'(obs_m.cen);
      if (obs_m.fdone) done_cyc = cyc;
      tick();
    end
    tests++;
    if (done_cyc != M_E + M_X + 1 + 2 ** M_BD + M_R + 1) begin fails++; $display("FAIL basic_frame_len: got %0d expected %0d", done_cyc, M_E + M_X + 1 + 2 ** M_BD + M_R + 1); end
    tests++;
    if (n_erase != 5 || n_expose != 255 || n_crst != 1 || n_cen != 1024) begin
      fails++;
      $display("FAIL basic_phase_lengths: got %0d/%0d/%0d/%0d expected 5/255/1/1024", n_erase, n_expose, n_crst, n_cen);
    end
  endtask

  task automatic test_backpressure();
    int stalls, row0_cycles;
    bit done;
    stalls = 0; row0_cycles = 0; done = 1'b0;
    m_start = 1'b1;
    m_ready = 1'($urandom_range(0, 1));
    tick();
    m_start = 1'b0;
    for (int cyc = 1; cyc < 3000 && !done; cyc++) begin
      tests++;
      if (obs_m !== expect_of(cfg_m, mm)) begin fails++; $display("FAIL backpressure cyc %0d: got %h expected %h", cyc, obs_m, expect_of(cfg_m, mm)); end
      if (obs_m.rvalid && obs_m.rsel == 8'd0) row0_cycles++;
      if (obs_m.fdone) done = 1'b1;
      if (obs_m.rvalid && stalls < 7) begin
        m_ready = 1'b0;
        stalls++;
      end else if (obs_m.rvalid) begin
        m_ready = 1'b1;
      end else begin
        m_ready = 1'($urandom_range(0, 1));
      end
      tick();
    end
    tests++;
    if (!done || row0_cycles != 8) begin fails++; $display("FAIL backpressure_row0: got %0d cycles done=%0d expected 8 cycles done=1", row0_cycles, done); end
  endtask

  task automatic test_ignored_start();
    int done_cyc;
    done_cyc = -1;
    m_ready = 1'b1;
    m_start = 1'b1;
    tick();
    m_start = 1'b0;
    for (int cyc = 1; cyc < 3000 && done_cyc < 0; cyc++) begin
      tests++;
      if (obs_m !== expect_of(cfg_m, mm)) begin fails++; $display("FAIL ignored_start cyc %0d: got %h expected %h", cyc, obs_m, expect_of(cfg_m, mm)); end
      if (obs_m.fdone) done_cyc = cyc;
      m_start = (obs_m.crst || obs_m.cen) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    m_start = 1'b0;
    tests++;
    if (done_cyc != M_E + M_X + 1 + 2 ** M_BD + M_R + 1) begin fails++; $display("FAIL ignored_start_len: got %0d expected %0d", done_cyc, M_E + M_X + 1 + 2 ** M_BD + M_R + 1); end
    for (int cyc = 0; cyc < 50; cyc++) begin
      tests++;
      if (obs_m !== expect_of(cfg_m, mm) || obs_m.busy !== 1'b0) begin fails++; $display("FAIL ignored_start_idle cyc %0d: got %h expected %h", cyc, obs_m, expect_of(cfg_m, mm)); end
      tick();
    end
  endtask

  task automatic test_random_ready();
    int frames;
    frames = 0;
    m_start = 1'b1;
    for (int cyc = 0; cyc < 8000 && frames < 2; cyc++) begin
      tests++;
      if (obs_m !== expect_of(cfg_m, mm)) begin fails++; $display("FAIL random_ready cyc %0d: got %h expected %h", cyc, obs_m, expect_of(cfg_m, mm)); end
      if (obs_m.fdone) frames++;
      m_ready = 1'($urandom_range(0, 1));
      m_start = ($urandom_range(0, 15) == 0);
      tick();
    end
    tests++;
    if (frames != 2) begin fails++; $display("FAIL random_ready_frames: got %0d expected 2", frames); end
    m_start = 1'b0;
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 3000 && mm.active && !CONT; cyc++) tick();
  endtask

  task automatic test_back_to_back();
    int frames;
    bit after_done;
    frames = 0; after_done = 1'b0;
    m_start = 1'b1;
    for (int cyc = 0; cyc < 8000 && frames < 2; cyc++) begin
      tests++;
      if (obs_m !== expect_of(cfg_m, mm)) begin fails++; $display("FAIL back_to_back cyc %0d: got %h expected %h", cyc, obs_m, expect_of(cfg_m, mm)); end
      if (after_done) begin
        tests++;
        if (obs_m.erase !== 1'b1) begin fails++; $display("FAIL back_to_back_restart: got erase=%b expected 1", obs_m.erase); end
        after_done = 1'b0;
      end
      if (obs_m.fdone) begin
        frames++;
        after_done = 1'b1;
      end
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    tests++;
    if (frames != 2) begin fails++; $display("FAIL back_to_back_frames: got %0d expected 2", frames); end
    m_start = 1'b0;
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 3000 && mm.active && !CONT; cyc++) tick();
  endtask

  task automatic test_edge_params();
    int n_cen, n_done, n_rows;
    n_cen = 0; n_done = 0; n_rows = 0;
    e_start = 1'b1;
    tick();
    e_start = 1'b0;
    for (int cyc = 1; cyc < 200 && n_done == 0; cyc++) begin
      tests++;
      if (obs_e !== expect_of(cfg_e, me)) begin fails++; $display("FAIL edge_params cyc %0d: got %h expected %h", cyc, obs_e, expect_of(cfg_e, me)); end
      tests++;
      if ($countones({obs_e.erase, obs_e.expose, obs_e.cen, obs_e.rvalid}) > 1) begin fails++; $display("FAIL edge_exclusive cyc %0d: got %h", cyc, obs_e); end
      n_cen += int'(obs_e.cen);
      n_done += int'(obs_e.fdone);
      e_ready = 1'($urandom_range(0, 1));
      if (obs_e.rvalid && e_ready) n_rows++;
      tick();
    end
    e_ready = 1'b0;
    tests++;
    if (n_cen != 4 || n_done != 1 || n_rows != 1) begin fails++; $display("FAIL edge_counts: got cen=%0d done=%0d rows=%0d expected 4/1/1", n_cen, n_done, n_rows); end
  endtask

  task automatic test_mid_reset();
    obs_t rexp;
    int guard;
    rexp = '0;
    rexp.crst = 1'b1;
    guard = 0;
    m_ready = 1'b1;
    m_start = 1'b1;
    tick();
    m_start = 1'b0;
    while (!(mm.active && mm.t == M_E + 100) && guard < 4000) begin
      tests++;
      if (obs_m !== expect_of(cfg_m, mm)) begin fails++; $display("FAIL mid_reset_run cyc %0d: got %h expected %h", guard, obs_m, expect_of(cfg_m, mm)); end
      tick();
      guard++;
    end
    tests++;
    if (obs_m.expose !== 1'b1 || guard >= 4000) begin fails++; $display("FAIL mid_reset_reach: got expose=%b guard=%0d expected expose=1", obs_m.expose, guard); end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (obs_m !== rexp) begin fails++; $display("FAIL mid_reset_async: got %h expected %h", obs_m, rexp); end
    repeat (2) begin
      @(posedge clk);
      #1;
      tests++;
      if (obs_m !== rexp) begin fails++; $display("FAIL mid_reset_hold: got %h expected %h", obs_m, rexp); end
    end
    rst = 1'b0;
    mm = idle_mdl;
    me = idle_mdl;
    for (int cyc = 0; cyc < 10; cyc++) begin
      tick();
      tests++;
      if (obs_m !== expect_of(cfg_m, mm) || obs_m.fdone !== 1'b0) begin fails++; $display("FAIL mid_reset_idle cyc %0d: got %h expected %h", cyc, obs_m, expect_of(cfg_m, mm)); end
    end
  endtask

  task automatic test_continuous();
    int frames;
    bit after_done;
    frames = 0; after_done = 1'b0;
    m_start = 1'b1;
    tick();
    m_start = 1'b0;
    for (int cyc = 1; cyc < 9000 && frames < 3; cyc++) begin
      tests++;
      if (obs_m !== expect_of(cfg_m, mm) || obs_m.busy !== 1'b1) begin fails++; $display("FAIL continuous cyc %0d: got %h expected %h", cyc, obs_m, expect_of(cfg_m, mm)); end
      if (after_done) begin
        tests++;
        if (obs_m.erase !== 1'b1) begin fails++; $display("FAIL continuous_erase_after_done: got %b expected 1", obs_m.erase); end
        after_done = 1'b0;
      end
      if (obs_m.fdone) begin
        frames++;
        after_done = 1'b1;
      end
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    tests++;
    if (frames != 3) begin fails++; $display("FAIL continuous_frames: got %0d expected 3", frames); end
  endtask

  initial begin
    idle_mdl = '{active: 1'b0, t: 0, row: 0, done: 1'b0};
    cfg_m = '{e: M_E, x: M_X, c: 2 ** M_BD, r: M_R, cont: CONT};
    cfg_e = '{e: E_E, x: E_X, c: 2 ** E_BD, r: E_R, cont: CONT};
    mm = idle_mdl;
    me = idle_mdl;
    test_reset();
    test_basic_frame();
`ifdef PIXEL_SEQ_CONTINUOUS_EN
    test_continuous();
    test_edge_params();
    test_mid_reset();
`else
    test_backpressure();
    test_ignored_start();
    test_random_ready();
    test_back_to_back();
    test_edge_params();
    test_mid_reset();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
